// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory/writeback stage between execute and the register file.
//            Each accepted instruction is either an ALU passthrough (1-cycle
//            writeback), a load over a valid/ready data bus, or a store over
//            the same bus. wb_addr/wb_data form the register-file write pair
//            and double as the mem-level forwarding source.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_*                - instruction from execute (valid/ready)
//            mem_req_*           - bus request (valid/ready), registered
//            mem_resp_*          - load data return (single-cycle pulse)
//            wb_addr, wb_data    - writeback pair (wb_addr pulses, 0 = none)
//            fault               - misalignment pulse (optional feature)
// Options  : MEM_STAGE_ALIGN_CHECK_EN - when defined, misaligned half/word
//            accesses are dropped and flagged on 'fault'; otherwise the low
//            address bits are silently ignored and fault is held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int RESP_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [3:0]            in_dest,
  input  logic [RESP_WIDTH-1:0] in_result,
  input  logic [RESP_WIDTH-1:0] in_store_data,
  input  logic [1:0]            in_size,
  input  logic                  in_signed,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [RESP_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [RESP_WIDTH-1:0] mem_req_wdata,
  output logic [STRB_WIDTH-1:0] mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [RESP_WIDTH-1:0] mem_resp_data,
  output logic [3:0]            wb_addr,
  output logic [RESP_WIDTH-1:0] wb_data,
  output logic                  fault
);

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                state_q,     state_d;
  logic                  req_valid_q, req_valid_d;
  logic [RESP_WIDTH-1:0] addr_q,      addr_d;
  logic                  we_q,        we_d;
  logic [RESP_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic [1:0]            size_q,      size_d;
  logic                  signed_q,    signed_d;
  logic [3:0]            dest_q,      dest_d;
  logic [3:0]            wb_addr_q,   wb_addr_d;
  logic [RESP_WIDTH-1:0] wb_data_q,   wb_data_d;
  logic                  fault_q,     fault_d;

  // Store formatting: replicate the value into every lane so the strobe
  // alone selects which bytes the memory actually writes.
  logic [RESP_WIDTH-1:0] fmt_wdata;
  logic [STRB_WIDTH-1:0] fmt_wstrb;

  always_comb begin
    fmt_wdata = in_store_data;
    fmt_wstrb = 4'b1111;
    case (in_size)
      SZ_BYTE: begin
        fmt_wdata = {4{in_store_data[7:0]}};
        fmt_wstrb = 4'b0001 << in_result[1:0];
      end
      SZ_HALF: begin
        fmt_wdata = {2{in_store_data[15:0]}};
        fmt_wstrb = in_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = in_store_data;
        fmt_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction uses the address/size/sign latched at acceptance.
  logic [RESP_WIDTH-1:0] resp_shift;
  logic [15:0]           resp_half;
  logic [RESP_WIDTH-1:0] load_value;

  always_comb begin
    resp_shift = mem_resp_data >> {addr_q[1:0], 3'b000};
    resp_half  = addr_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
    case (size_q)
      SZ_BYTE: load_value = {{24{signed_q & resp_shift[7]}}, resp_shift[7:0]};
      SZ_HALF: load_value = {{16{signed_q & resp_half[15]}}, resp_half};
      default: load_value = mem_resp_data;
    endcase
  end

  logic misaligned;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misaligned = ((in_size == SZ_HALF) && in_result[0]) ||
                      (in_size[1] && (in_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;
    signed_d    = signed_q;
    dest_d      = dest_q;
    wb_addr_d   = 4'd0;        // writeback address is a single-cycle pulse
    wb_data_d   = wb_data_q;
    fault_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_op == OP_ALU) begin
            wb_addr_d = in_dest;
            if (in_dest != 4'd0) wb_data_d = in_result;
          end else if ((in_op == OP_LOAD) || (in_op == OP_STORE)) begin
            if (misaligned) begin
              fault_d = 1'b1;
            end else begin
              state_d     = ST_REQ;
              req_valid_d = 1'b1;
              addr_d      = in_result;
              we_d        = (in_op == OP_STORE);
              wdata_d     = (in_op == OP_STORE) ? fmt_wdata : '0;
              wstrb_d     = (in_op == OP_STORE) ? fmt_wstrb : '0;
              size_d      = in_size;
              signed_d    = in_signed;
              dest_d      = in_dest;
            end
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          // Stores complete on acceptance; only loads wait for data.
          state_d     = we_q ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          wb_addr_d = dest_q;
          if (dest_q != 4'd0) wb_data_d = load_value;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      dest_q      <= 4'd0;
      wb_addr_q   <= 4'd0;
      wb_data_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      dest_q      <= dest_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fault_q     <= fault_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Expected writebacks are queued
//            when an instruction is driven and popped by a negedge monitor
//            whenever the DUT presents a non-zero wb_addr.
// Options  : honours MEM_STAGE_ALIGN_CHECK_EN for the misaligned-load case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_dest;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [1:0]  in_size;
  logic        in_signed;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fault;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_dest       (in_dest),
    .in_result     (in_result),
    .in_store_data (in_store_data),
    .in_size       (in_size),
    .in_signed     (in_signed),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .fault         (fault)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] sb_q[$];   // {dest, data} of expected writebacks, in order
  logic [35:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Writeback monitor: every non-zero wb_addr must match the queue head.
  always @(negedge clk) begin
    if (!rst && wb_addr != 4'd0) begin
      if (sb_q.size() == 0) begin
        check("wb_spurious", {28'd0, wb_addr}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_addr", {28'd0, wb_addr}, {28'd0, mon_e[35:32]});
        check("wb_data", wb_data, mon_e[31:0]);
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic issue(input logic [1:0] op, input logic [3:0] dest, input logic [31:0] res,
                       input logic [31:0] sd, input logic [1:0] sz, input logic sg);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    in_op         = op;
    in_dest       = dest;
    in_result     = res;
    in_store_data = sd;
    in_size       = sz;
    in_signed     = sg;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    in_op         = 2'b11;
  endtask

  task automatic drain;
    @(negedge clk); #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic alu(input logic [3:0] dest, input logic [31:0] res);
    if (dest != 4'd0) sb_q.push_back({dest, res});
    issue(2'b00, dest, res, 32'h0, 2'b10, 1'b0);
  endtask

  // Checks the held request each cycle, then accepts it after ready_delay cycles.
  task automatic bus_handshake(input int ready_delay, input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    for (int i = 0; i <= ready_delay; i++) begin
      check("req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("req_addr",  mem_req_addr, addr);
      check("req_we",    {31'd0, mem_req_we}, {31'd0, we});
      check("req_wdata", mem_req_wdata, wdata);
      check("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, wstrb});
      check("in_ready_req", {31'd0, in_ready}, 32'd0);
      if (i == ready_delay) mem_req_ready = 1'b1;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    check("req_dropped", {31'd0, mem_req_valid}, 32'd0);
  endtask

  task automatic load(input logic [3:0] dest, input logic [31:0] addr, input logic [1:0] sz,
                      input logic sg, input int ready_delay, input int resp_delay,
                      input logic [31:0] resp, input logic [31:0] exp);
    issue(2'b01, dest, addr, 32'h5A5A_5A5A, sz, sg);
    bus_handshake(ready_delay, addr, 1'b0, 32'h0, 4'h0);
    repeat (resp_delay) begin
      check("in_ready_wait", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    if (dest != 4'd0) sb_q.push_back({dest, exp});
    mem_resp_valid = 1'b1;
    mem_resp_data  = resp;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = ~resp;
    check("in_ready_after_resp", {31'd0, in_ready}, 32'd1);
    drain();
  endtask

  task automatic store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                       input int ready_delay);
    issue(2'b10, 4'd7, addr, d, sz, 1'b0);
    bus_handshake(ready_delay, addr, 1'b1, exp_wdata, exp_wstrb);
    check("store_in_ready", {31'd0, in_ready}, 32'd1);
    drain();
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_op          = 2'b11;
    in_dest        = 4'd0;
    in_result      = 32'h0;
    in_store_data  = 32'h0;
    in_size        = 2'b00;
    in_signed      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_addr",   {28'd0, wb_addr}, 32'd0);
    check("rst_wb_data",   wb_data, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_addr",  mem_req_addr, 32'd0);
    check("rst_fault",     {31'd0, fault}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Back-to-back ALU passthrough, then dest 0 and nop (no writeback).
    alu(4'd1, 32'h11);
    alu(4'd2, 32'h22);
    alu(4'd3, 32'h33);
    drain();
    alu(4'd0, 32'h44);
    issue(2'b11, 4'd4, 32'h55, 32'h0, 2'b10, 1'b0);
    drain();

    // Loads: byte/half/word, signed and unsigned, various bus delays.
    load(4'd5,  32'h1003, 2'b00, 1'b1, 3, 2, 32'h80FF_FF7F, 32'hFFFF_FF80);
    load(4'd6,  32'h1003, 2'b00, 1'b0, 0, 0, 32'h80FF_FF7F, 32'h0000_0080);
    load(4'd8,  32'h1001, 2'b00, 1'b1, 1, 1, 32'h1234_A5C6, 32'hFFFF_FFA5);
    load(4'd9,  32'h1002, 2'b01, 1'b0, 0, 3, 32'h80FF_FF7F, 32'h0000_80FF);
    load(4'd10, 32'h1000, 2'b01, 1'b1, 2, 0, 32'h80FF_FF7F, 32'hFFFF_FF7F);
    load(4'd11, 32'h1004, 2'b10, 1'b1, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load(4'd12, 32'h1008, 2'b11, 1'b0, 1, 0, 32'h0BAD_F00D, 32'h0BAD_F00D);
    load(4'd0,  32'h100C, 2'b10, 1'b0, 0, 0, 32'h1111_2222, 32'h1111_2222);

    // Stores: lane replication and strobes.
    store(32'h2002, 2'b01, 32'hABCD_1234, 32'h1234_1234, 4'b1100, 2);
    store(32'h2000, 2'b01, 32'hABCD_5678, 32'h5678_5678, 4'b0011, 0);
    store(32'h2001, 2'b00, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b0010, 1);
    store(32'h2003, 2'b00, 32'h0000_003C, 32'h3C3C_3C3C, 4'b1000, 0);
    store(32'h2000, 2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 0);

    // Reset while waiting for load data: the late response must be ignored.
    issue(2'b01, 4'd13, 32'h1000, 32'h0, 2'b10, 1'b0);
    bus_handshake(0, 32'h1000, 1'b0, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    check("rstw_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rstw_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rstw_wb_addr",   {28'd0, wb_addr}, 32'd0);
    drain();

    // Misaligned word load.
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    issue(2'b01, 4'd14, 32'h3001, 32'h0, 2'b10, 1'b0);
    check("mis_fault",     {31'd0, fault}, 32'd1);
    check("mis_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("mis_in_ready",  {31'd0, in_ready}, 32'd1);
    check("mis_wb_addr",   {28'd0, wb_addr}, 32'd0);
    @(posedge clk); #1;
    check("mis_fault_end", {31'd0, fault}, 32'd0);
    check("mis_req_end",   {31'd0, mem_req_valid}, 32'd0);
    drain();
`else
    load(4'd14, 32'h3001, 2'b10, 1'b0, 0, 1, 32'h89AB_CDEF, 32'h89AB_CDEF);
    check("mis_no_fault", {31'd0, fault}, 32'd0);
`endif

    // ALU after all the bus traffic still writes back in one cycle.
    alu(4'd15, 32'hFEED_0001);
    drain();

    check("sb_final", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory/writeback stage between execute and the register file write port. Takes one executed instruction per handshake and either:
- passes its ALU result through,
- performs a load over a valid/ready data bus, or
- performs a store over the same bus.
Drives the register file writeback pair (wb_addr/wb_data), which also serves as the mem-level forwarding source.

Parameters:
RESP_WIDTH, 32, width of bus read data and register data (fixed 32; other values unsupported)
STRB_WIDTH, 4, byte strobes per bus word (RESP_WIDTH/8)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  execute offers an instruction
in_ready  out  1  stage can accept (high only in IDLE)
in_op  in  2  00 ALU passthrough, 01 load, 10 store, 11 nop
in_dest  in  4  destination register; 0 = no write
in_result  in  32  ALU result; byte address for load/store
in_store_data  in  32  store value (unshifted, low bits significant)
in_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
in_signed  in  1  load sign-extends when 1, zero-extends when 0
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  32  byte address (unmodified in_result)
mem_req_we  out  1  1 store, 0 load
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte enables (all 0 for loads)
mem_resp_valid  in  1  load data returned (one cycle pulse)
mem_resp_data  in  32  load word
wb_addr  out  4  register file write address; 0 = no write
wb_data  out  32  register file write data
fault  out  1  one-cycle misalignment pulse (feature only; else tied 0)

Behaviour:
- Reset (sync, high) values: state IDLE; mem_req_valid=0; wb_addr=0; wb_data=0; fault=0; mem_req_* registers 0.
- Reset mid-transaction abandons it; no writeback is produced.
- States:
  - IDLE
    - in_ready=1.
    - On in_valid with op 00: next cycle wb_addr=in_dest, wb_data=in_result. 1-cycle latency, back-to-back every cycle.
    - op 11: consumed, no effect.
    - op 01/10: latch address, size, sign, dest and formatted store data; go REQ. mem_req_valid=1 from the next cycle.
  - REQ
    - in_ready=0.
    - mem_req_* held stable until mem_req_ready=1.
    - On handshake: store returns to IDLE (complete on acceptance, no response expected); load goes to WAIT.
  - WAIT
    - in_ready=0.
    - On mem_resp_valid: extract lane by addr[1:0], sign- or zero-extend, register into wb_addr/wb_data next cycle; return to IDLE in that same next cycle.
- wb_addr is a one-cycle pulse; it returns to 0 every cycle without a new writeback. wb_data holds its last value.
- Store formatting:
  - byte: wdata = {4{d[7:0]}}, wstrb = 1<<addr[1:0].
  - half: wdata = {2{d[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - word: wdata = d, wstrb = 1111.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lane addr[1] (addr[0] ignored).
  - word: full word.
- Without the feature, misalignment is silently ignored: low address bits are dropped as described above.
- mem_resp_valid outside WAIT is ignored.
- Load with in_dest=0 still performs the bus access; wb_addr stays 0.
- Load latency: accept at T, mem_req_valid at T+1. If ready at T+1 and resp at T+k, writeback is visible at T+k+1 and in_ready=1 at T+k+1.

Optional Feature:
MEM_STAGE_ALIGN_CHECK_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request.
  - fault=1 for exactly the cycle after acceptance; stage stays in IDLE; wb_addr=0.
- Undefined: no check; fault tied 0.

Test Plan:
- ALU ops on 3 consecutive cycles (dest 1,2,3; results 0x11,0x22,0x33), in_ready stays 1 → wb_addr/wb_data = 1/0x11, 2/0x22, 3/0x33 on cycles T+1..T+3.
- Signed byte load, addr 0x1003, mem_req_ready held low 3 cycles, resp 0x80FFFF7F → request held stable, wb_data=0x00000080 sign-extended to 0xFFFFFF80 wb_addr=dest; with in_signed=0 → 0x00000080.
- Half store, addr 0x2002, data 0xABCD1234 → mem_req_wdata=0x12341234, wstrb=1100, we=1; no writeback; in_ready=1 the cycle after handshake.
- Reset asserted in WAIT, then resp pulse → no writeback, mem_req_valid=0, in_ready=1 after reset.
- Word load at 0x3001: feature defined → fault pulse, no mem_req_valid, wb_addr=0; feature undefined → request issued at 0x3001, full word written back.
